// File: rtl/up_cmd_initiator.sv
// up_cmd_initiator: turns a valid/ready command stream into single up_* register-bus accesses
// and returns a valid/ready response with read data and a timeout flag.
module up_cmd_initiator #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                  up_clk,
    input  logic                  up_rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_timeout,
    output logic                  up_wreq,
    output logic [ADDR_WIDTH-1:0] up_waddr,
    output logic [31:0]           up_wdata,
    input  logic                  up_wack,
    output logic                  up_rreq,
    output logic [ADDR_WIDTH-1:0] up_raddr,
    input  logic [31:0]           up_rdata,
    input  logic                  up_rack,
    output logic                  busy,
    output logic [7:0]            timeout_count
);
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  up_wreq_q, up_wreq_d;
    logic                  up_rreq_q, up_rreq_d;
    logic [ADDR_WIDTH-1:0] up_waddr_q, up_waddr_d;
    logic [ADDR_WIDTH-1:0] up_raddr_q, up_raddr_d;
    logic [31:0]           up_wdata_q, up_wdata_d;
    logic                  busy_q, busy_d;
    logic [7:0]            tcnt_q, tcnt_d;
    logic                  ack, expire;

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign up_wreq       = up_wreq_q;
    assign up_rreq       = up_rreq_q;
    assign up_waddr      = up_waddr_q;
    assign up_raddr      = up_raddr_q;
    assign up_wdata      = up_wdata_q;
    assign busy          = busy_q;
    assign timeout_count = tcnt_q;

    // Only the ack type matching the latched command counts; a timeout limit of 0 never expires.
    assign ack    = write_q ? up_wack : up_rack;
    assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        write_d       = write_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        up_wreq_d     = 1'b0;
        up_rreq_d     = 1'b0;
        up_waddr_d    = up_waddr_q;
        up_raddr_d    = up_raddr_q;
        up_wdata_d    = up_wdata_q;
        tcnt_d        = tcnt_q;
        unique case (state_q)
            IDLE: if (cmd_valid && cmd_ready_q) begin
                write_d     = cmd_write;
                up_waddr_d  = cmd_addr;
                up_raddr_d  = cmd_addr;
                up_wdata_d  = cmd_wdata;
                up_wreq_d   = cmd_write;
                up_rreq_d   = !cmd_write;
                cmd_ready_d = 1'b0;
                state_d     = REQ;
            end
            REQ: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (ack) begin
                rsp_valid_d   = 1'b1;
                rsp_write_d   = write_q;
                rsp_rdata_d   = write_q ? 32'd0 : up_rdata;
                rsp_timeout_d = 1'b0;
                state_d       = RESP;
            end else if (expire) begin
                rsp_valid_d   = 1'b1;
                rsp_write_d   = write_q;
                rsp_rdata_d   = 32'd0;
                rsp_timeout_d = 1'b1;
                tcnt_d        = tcnt_q + {7'd0, tcnt_q != 8'hFF};
                state_d       = RESP;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            write_q       <= 1'b0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            up_wreq_q     <= 1'b0;
            up_rreq_q     <= 1'b0;
            up_waddr_q    <= '0;
            up_raddr_q    <= '0;
            up_wdata_q    <= '0;
            busy_q        <= 1'b0;
            tcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            write_q       <= write_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
            up_wreq_q     <= up_wreq_d;
            up_rreq_q     <= up_rreq_d;
            up_waddr_q    <= up_waddr_d;
            up_raddr_q    <= up_raddr_d;
            up_wdata_q    <= up_wdata_d;
            busy_q        <= busy_d;
            tcnt_q        <= tcnt_d;
        end
    end
endmodule

// File: tb/tb_up_cmd_initiator.sv
// tb_up_cmd_initiator: directed vector bench for up_cmd_initiator with an inline responder
// that acks a chosen number of WAIT cycles after the request strobe.
module tb_up_cmd_initiator;
    logic        up_clk = 1'b0;
    logic        up_rstn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic        up_wack = 1'b0, up_rack = 1'b0;
    logic [31:0] up_rdata = '0;
    logic        cmd_ready, rsp_valid, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata, up_wdata;
    logic        up_wreq, up_rreq, busy;
    logic [7:0]  up_waddr, up_raddr, timeout_count;

    up_cmd_initiator #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(32)) dut (
        .up_clk(up_clk), .up_rstn(up_rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
        .busy(busy), .timeout_count(timeout_count)
    );

    always #5 up_clk = ~up_clk;

    // ack_at: WAIT cycle (1-based) carrying the matching ack, 0 = never.
    // exp_k: negedge count after the strobe cycle at which rsp_valid is first seen.
    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;
        logic        wrong;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_to;
        int          exp_k;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   fails = 0;
    int   tcnt_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run(input vec_t v);
        int   k;
        logic seen;
        @(negedge up_clk);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        @(negedge up_clk);
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 32'd0;
        chk("up_wreq_req", {31'd0, up_wreq}, {31'd0, v.wr});
        chk("up_rreq_req", {31'd0, up_rreq}, {31'd0, !v.wr});
        chk("up_waddr", {24'd0, up_waddr}, {24'd0, v.addr});
        chk("up_raddr", {24'd0, up_raddr}, {24'd0, v.addr});
        if (v.wr) chk("up_wdata", up_wdata, v.wdata);
        chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            @(negedge up_clk);
            k++;
            up_wack = 1'b0; up_rack = 1'b0; up_rdata = 32'd0;
            if (rsp_valid) seen = 1'b1;
            else begin
                chk("strobes_wait", {30'd0, up_wreq, up_rreq}, 32'd0);
                chk("addr_stable", {24'd0, up_waddr}, {24'd0, v.addr});
                if (k == v.ack_at) begin
                    if (v.wr) up_wack = 1'b1; else up_rack = 1'b1;
                    up_rdata = v.rdata;
                end else if (v.wrong) begin
                    if (v.wr) up_rack = 1'b1; else up_wack = 1'b1;
                    up_rdata = 32'hBAD0BAD0;
                end
            end
        end
        up_wack = 1'b0; up_rack = 1'b0; up_rdata = 32'd0;
        chk("rsp_latency", k, v.exp_k);
        if (v.exp_to && tcnt_m < 255) tcnt_m++;
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_write", {31'd0, rsp_write}, {31'd0, v.wr});
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, v.exp_to});
        chk("timeout_count", {24'd0, timeout_count}, 32'(tcnt_m));
        chk("busy_resp", {31'd0, busy}, 32'd1);
        for (int h = 0; h < v.hold; h++) begin
            cmd_valid = 1'b1; cmd_write = !v.wr; cmd_addr = 8'hFF;
            @(negedge up_clk);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, v.exp_rdata);
            chk("hold_timeout", {31'd0, rsp_timeout}, {31'd0, v.exp_to});
            chk("hold_write", {31'd0, rsp_write}, {31'd0, v.wr});
            chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("hold_no_strobe", {30'd0, up_wreq, up_rreq}, 32'd0);
        end
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00;
        rsp_ready = 1'b1;
        @(negedge up_clk);
        rsp_ready = 1'b0;
        chk("rsp_done_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rsp_done_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rsp_done_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_write", {31'd0, rsp_write}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("rst_strobes", {30'd0, up_wreq, up_rreq}, 32'd0);
        chk("rst_addrs", {16'd0, up_waddr, up_raddr}, 32'd0);
        chk("rst_wdata", up_wdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_timeout_count", {24'd0, timeout_count}, 32'd0);
    endtask

    initial begin
        vec_t vto;
        vecs[0] = '{1'b1, 8'h02, 32'hDEADBEEF, 32'h00000000, 1,  1'b0, 0, 32'h00000000, 1'b0, 2};
        vecs[1] = '{1'b0, 8'h03, 32'h00000000, 32'h41494F4E, 1,  1'b0, 0, 32'h41494F4E, 1'b0, 2};
        vecs[2] = '{1'b0, 8'h10, 32'h00000000, 32'h77777777, 0,  1'b1, 0, 32'h00000000, 1'b1, 33};
        vecs[3] = '{1'b0, 8'h11, 32'h00000000, 32'h12345678, 32, 1'b1, 0, 32'h12345678, 1'b0, 33};
        vecs[4] = '{1'b1, 8'h20, 32'hCAFEF00D, 32'h55AA55AA, 5,  1'b0, 5, 32'h00000000, 1'b0, 6};
        vecs[5] = '{1'b1, 8'h21, 32'h00000001, 32'h00000000, 0,  1'b1, 2, 32'h00000000, 1'b1, 33};
        vecs[6] = '{1'b0, 8'h22, 32'h00000000, 32'hA5A50F0F, 3,  1'b1, 1, 32'hA5A50F0F, 1'b0, 4};
        vto     = '{1'b0, 8'h30, 32'h00000000, 32'h00000000, 0,  1'b0, 0, 32'h00000000, 1'b1, 33};

        repeat (2) @(negedge up_clk);
        chk_reset_outputs();
        up_rstn = 1'b1;

        for (int i = 0; i < 7; i++) run(vecs[i]);

        // stray read ack in IDLE must not produce a response or change state
        @(negedge up_clk);
        up_rack = 1'b1; up_rdata = 32'h99999999;
        repeat (2) @(negedge up_clk);
        up_rack = 1'b0; up_rdata = 32'd0;
        chk("stray_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("stray_busy", {31'd0, busy}, 32'd0);
        chk("stray_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("stray_timeout_count", {24'd0, timeout_count}, 32'(tcnt_m));

        // asynchronous reset in the middle of WAIT
        @(negedge up_clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h05;
        @(negedge up_clk);
        cmd_valid = 1'b0; cmd_addr = 8'h00;
        repeat (3) @(negedge up_clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1 up_rstn = 1'b0;
        #1 tcnt_m = 0;
        chk_reset_outputs();
        @(negedge up_clk);
        up_rstn = 1'b1;
        repeat (40) @(negedge up_clk);
        chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);

        // saturation of the timeout counter
        for (int i = 0; i < 260; i++) run(vto);
        chk("timeout_count_sat", {24'd0, timeout_count}, 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/up_cmd_initiator.md
Name: up_cmd_initiator

Overview:
- Initiator (master) for the team's `up_*` register bus; drives `up_wreq`/`up_rreq` toward a register-map responder and collects `up_wack`/`up_rack`.
- Converts a valid/ready command stream (read or write, address, data) into single bus accesses. Returns a valid/ready response carrying read data and a timeout flag.
- Used for boot-time register sequencing and for self-test of peripheral register maps without a processor.
- Exactly one outstanding transaction at a time.

Parameters:
- ADDR_WIDTH, 8: width of `cmd_addr`, `up_waddr`, `up_raddr`.
- TIMEOUT_CYCLES, 32: max cycles spent waiting for an ack before aborting; 0 = wait forever.

Ports:
- up_clk  in  1  sole clock.
- up_rstn  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when `cmd_valid & cmd_ready`.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  register address.
- cmd_wdata  in  32  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when `rsp_valid & rsp_ready`.
- rsp_write  out  1  echo of `cmd_write`.
- rsp_rdata  out  32  read data; 0 for writes and for timeouts.
- rsp_timeout  out  1  1 = no ack within TIMEOUT_CYCLES.
- up_wreq  out  1  write request strobe.
- up_waddr  out  ADDR_WIDTH  write address.
- up_wdata  out  32  write data.
- up_wack  in  1  write acknowledge.
- up_rreq  out  1  read request strobe.
- up_raddr  out  ADDR_WIDTH  read address.
- up_rdata  in  32  read data, valid in the `up_rack` cycle.
- up_rack  in  1  read acknowledge.
- busy  out  1  state != IDLE.
- timeout_count  out  8  saturating count of timed-out transactions.

Behaviour:
- Reset values: all outputs 0, except `cmd_ready` = 1. The FSM enters IDLE and the timeout counter clears. A reset mid-transaction discards the command silently; no response is produced.
- FSM states: IDLE, REQ, WAIT, RESP. All outputs are registered.
- IDLE:
  - `cmd_ready` = 1.
  - On handshake: latch write/addr/wdata, drive `up_waddr`/`up_raddr`/`up_wdata` from the latched values, `cmd_ready` goes to 0, next state REQ.
- REQ:
  - Exactly one cycle: `up_wreq` = 1 (write) or `up_rreq` = 1 (read), never both.
  - Addr/data are stable from this cycle until leaving WAIT.
  - Next state WAIT. Any ack seen during REQ is ignored, because the responder acks no earlier than the cycle after the request.
- WAIT:
  - Request strobes are 0.
  - A write completes on `up_wack` = 1; a read completes on `up_rack` = 1, capturing `up_rdata` into `rsp_rdata`.
  - The non-matching ack type is ignored. On completion the next state is RESP with `rsp_timeout` = 0.
  - The cycle counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES with no matching ack, the next state is RESP with `rsp_timeout` = 1, `rsp_rdata` = 0, and `timeout_count` increments (holds at 255).
  - If the ack and the timeout fall in the same cycle, the ack wins (no timeout).
- RESP:
  - `rsp_valid` = 1; `rsp_write`, `rsp_rdata` and `rsp_timeout` are held stable until `rsp_ready`.
  - On handshake: `rsp_valid` goes to 0, next state IDLE, `cmd_ready` = 1 in the following cycle.
- Acks outside WAIT are ignored. A late ack after a timeout is dropped, not attributed to a later command.
- Latency with a one-cycle-ack responder:
  - cmd handshake at cycle 0, strobe at cycle 1, ack at cycle 2, `rsp_valid` at cycle 3.
  - Peak throughput: one transaction per 4 cycles with `rsp_ready` held at 1.
- Write responses return `rsp_rdata` = 0 even if the responder drives `up_rdata`.

Test Plan:
- Write cmd addr 0x02, data 0xDEADBEEF against a responder model with a 1-cycle ack -> `up_wreq` high for exactly cycle 1 with `up_waddr` = 0x02 and `up_wdata` = 0xDEADBEEF; `rsp_valid` at cycle 3 with `rsp_write` = 1, `rsp_timeout` = 0, `rsp_rdata` = 0.
- Read cmd addr 0x03, responder returns 0x41494F4E with `up_rack` -> `up_rreq` one cycle, `rsp_rdata` = 0x41494F4E, `rsp_timeout` = 0; `up_wreq` never asserted.
- Read cmd, responder never acks, TIMEOUT_CYCLES = 32 -> `rsp_valid` after 32 WAIT cycles with `rsp_timeout` = 1, `rsp_rdata` = 0, `timeout_count` 0 -> 1. A stray `up_rack` then arrives in IDLE -> no response, no state change.
- `rsp_ready` held low for 5 cycles -> `rsp_*` stable, `cmd_ready` = 0, `cmd_valid` not accepted; `rsp_ready` rises -> IDLE and `cmd_ready` = 1 the next cycle.
- Ack arrives on the exact cycle the counter hits TIMEOUT_CYCLES -> normal response, `rsp_timeout` = 0; `up_wack` during a read WAIT -> ignored.
- `up_rstn` pulsed low during WAIT -> all outputs at reset values immediately, no `rsp_valid`. Run 260 timed-out commands -> `timeout_count` saturates at 255.
